// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMove = 2'd1,
    StDoor = 2'd2,
    StHalt = 2'd3
  } state_e;

  // Ceiling log2 for counter sizing; callers clamp the argument to at least 2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((res < 32) && ((64'd1 << res) < 64'(value))) res++;
    return res;
  endfunction

  // True when the car should open at the floor it has just reached.
  function automatic logic stop_at(input logic dir_up, input logic car_here,
                                   input logic up_here, input logic dn_here,
                                   input logic above, input logic below);
    if (dir_up) return car_here | up_here | (dn_here & ~above);
    else        return car_here | dn_here | (up_here & ~below);
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational view of the pending calls relative to one floor.
module elevator_req_scan #(
  parameter int unsigned FLOORS = 8,
  parameter int unsigned POS_W  = 3
) (
  input  logic [FLOORS-1:0] car_pend,
  input  logic [FLOORS-1:0] up_pend,
  input  logic [FLOORS-1:0] dn_pend,
  input  logic [POS_W-1:0]  floor_pos,
  output logic              req_above,
  output logic              req_below,
  output logic              req_here_up,
  output logic              req_here_dn,
  output logic              req_here_car
);

  logic [FLOORS-1:0] all_pend;
  logic [FLOORS-1:0] here_mask;
  logic [FLOORS-1:0] below_mask;
  logic [FLOORS-1:0] above_mask;

  // Split the floor range into below / here / above and reduce each class.
  always_comb begin
    all_pend     = car_pend | up_pend | dn_pend;
    here_mask    = FLOORS'(1) << floor_pos;
    below_mask   = here_mask - FLOORS'(1);
    above_mask   = ~(below_mask | here_mask);
    req_above    = |(all_pend & above_mask);
    req_below    = |(all_pend & below_mask);
    req_here_up  = |(up_pend & here_mask);
    req_here_dn  = |(dn_pend & here_mask);
    req_here_car = |(car_pend & here_mask);
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN car controller: latches three call classes, travels floor to floor,
// dwells with the door open and halts on emergency stop.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS        = 8,
  parameter int unsigned POS_W         = 3,
  parameter int unsigned DOOR_OPEN     = 5,
  parameter int unsigned TRAVEL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] car_req,
  input  logic [FLOORS-1:0] hall_up_req,
  input  logic [FLOORS-1:0] hall_dn_req,
  input  logic              door_hold,
  input  logic              estop,
  output logic [POS_W-1:0]  floor_pos,
  output logic              door_open,
  output logic              moving_up,
  output logic              moving_down,
  output logic [FLOORS-1:0] car_pend,
  output logic [FLOORS-1:0] up_pend,
  output logic [FLOORS-1:0] dn_pend
);

  localparam int unsigned TravW = clog2((TRAVEL_CYCLES < 2) ? 2 : TRAVEL_CYCLES);
  localparam int unsigned DoorW = clog2((DOOR_OPEN < 2) ? 2 : DOOR_OPEN);
  localparam logic [TravW-1:0]  TravLast = TravW'(TRAVEL_CYCLES - 1);
  localparam logic [DoorW-1:0]  DoorLast = DoorW'(DOOR_OPEN - 1);
  localparam logic [POS_W-1:0]  TopFloor = POS_W'(FLOORS - 1);
  // No up-call from the top floor, no down-call from the ground floor.
  localparam logic [FLOORS-1:0] UpValid  = ~(FLOORS'(1) << (FLOORS - 1));
  localparam logic [FLOORS-1:0] DnValid  = ~FLOORS'(1);

  state_e            state_q, state_d;
  logic [POS_W-1:0]  floor_q, floor_d;
  logic              dir_q, dir_d;
  logic [TravW-1:0]  trav_q, trav_d;
  logic [DoorW-1:0]  door_q, door_d;
  logic [FLOORS-1:0] car_q, car_d, up_q, up_d, dn_q, dn_d;

  logic [FLOORS-1:0] car_m, up_m, dn_m;
  logic [FLOORS-1:0] here_mask, svc_mask;
  logic              here_req, step, end_d, svc;
  logic              above, below, here_up, here_dn, here_car;

  // Pending view including this cycle's requests, so a call acts immediately.
  assign car_m     = car_q | car_req;
  assign up_m      = (up_q | hall_up_req) & UpValid;
  assign dn_m      = (dn_q | hall_dn_req) & DnValid;
  assign here_mask = FLOORS'(1) << floor_q;
  assign svc_mask  = FLOORS'(1) << floor_d;
  assign here_req  = |((car_req | (hall_up_req & UpValid) | (hall_dn_req & DnValid)) & here_mask);
  assign end_d     = dir_q ? (floor_d == TopFloor) : (floor_d == '0);

  // Scan against the floor the car will occupy after this edge.
  elevator_req_scan #(
    .FLOORS (FLOORS),
    .POS_W  (POS_W)
  ) u_scan (
    .car_pend     (car_m),
    .up_pend      (up_m),
    .dn_pend      (dn_m),
    .floor_pos    (floor_d),
    .req_above    (above),
    .req_below    (below),
    .req_here_up  (here_up),
    .req_here_dn  (here_dn),
    .req_here_car (here_car)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      floor_q <= '0;
      dir_q   <= 1'b1;
      trav_q  <= '0;
      door_q  <= '0;
      car_q   <= '0;
      up_q    <= '0;
      dn_q    <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      trav_q  <= trav_d;
      door_q  <= door_d;
      car_q   <= car_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end
  end

  // Travel counter and floor step; never steps past either end.
  always_comb begin
    floor_d = floor_q;
    trav_d  = '0;
    step    = 1'b0;
    if (state_q == StMove && !estop) begin
      if (trav_q != TravLast) begin
        trav_d = trav_q + TravW'(1);
      end else if (dir_q && floor_q != TopFloor) begin
        step    = 1'b1;
        floor_d = floor_q + POS_W'(1);
      end else if (!dir_q && floor_q != '0) begin
        step    = 1'b1;
        floor_d = floor_q - POS_W'(1);
      end
    end
  end

  // Next state, direction and door dwell counter.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    door_d  = '0;
    if (estop) begin
      state_d = StHalt;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (here_car || here_up || here_dn) begin
            state_d = StDoor;
          end else if (above && !below) begin
            dir_d   = 1'b1;
            state_d = StMove;
          end else if (below && !above) begin
            dir_d   = 1'b0;
            state_d = StMove;
          end else if (above && below) begin
            state_d = StMove;
          end
        end
        StMove: begin
          if (trav_q == TravLast) begin
            if (step && stop_at(dir_q, here_car, here_up, here_dn, above, below)) begin
              state_d = StDoor;
            end else if (end_d) begin
              state_d = StIdle;
            end
          end
        end
        StDoor: begin
          if (door_hold || here_req) begin
            door_d = '0;
          end else if (door_q != DoorLast) begin
            door_d = door_q + DoorW'(1);
          end else if (dir_q ? above : below) begin
            state_d = StMove;
          end else if (dir_q ? below : above) begin
            dir_d   = ~dir_q;
            state_d = StMove;
          end else begin
            state_d = StIdle;
          end
        end
        StHalt:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Request latching with service clearing at the door floor.
  always_comb begin
    svc  = (state_d == StDoor) || (state_q == StDoor);
    car_d = car_m;
    up_d  = up_m;
    dn_d  = dn_m;
    if (svc) begin
      car_d = car_m & ~svc_mask;
      if (dir_q || !above) up_d = up_m & ~svc_mask;
      if (!dir_q || !below) dn_d = dn_m & ~svc_mask;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    door_open   = (state_q == StDoor);
    moving_up   = (state_q == StMove) && dir_q;
    moving_down = (state_q == StMove) && !dir_q;
    floor_pos   = floor_q;
    car_pend    = car_q;
    up_pend     = up_q;
    dn_pend     = dn_q;
  end

endmodule
